// File: rtl/srff_cmd_arbiter.sv
// Round-robin arbiter that shares one srff between NREQ requesters, issuing a one-cycle SR command per grant.
// Optional readback check of the flip-flop output is enabled by defining SRFF_ARB_CHECK_EN.
module srff_cmd_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] cmd,
  input  logic              q_in,
  output logic [1:0]        sr_out,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ISSUE  = 2'd2,
    SETTLE = 2'd3
  } state_e;

  // Handshake: a requester holds req high until it sees its one-cycle gnt
  // pulse; cmd for that requester must be stable when req is first seen.
  state_e          state;
  logic [NREQ-1:0] req_r;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   w_r;
  logic [PW-1:0]   win;
  logic            found;
  logic [PW:0]     idx;
  logic [1:0]      cmd_r;
  logic            err_r;

  // Search the registered request vector starting at ptr, wrapping at NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_r[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

`ifdef SRFF_ARB_CHECK_EN
  logic q_prev;
  logic q_exp;
  logic chk_err;

  always_comb begin
    q_exp = q_prev;
    if (cmd_r == 2'b10) q_exp = 1'b1;
    else if (cmd_r == 2'b01) q_exp = 1'b0;
  end

  // The flip-flop captures the command at the edge entering SETTLE, so q_in
  // already shows the result while done is high.
  assign chk_err = (state == SETTLE) && (q_in != q_exp);
  assign err     = err_r | chk_err;

  always_ff @(posedge clk) begin
    if (rst) q_prev <= 1'b0;
    else if (state == IDLE && found) q_prev <= q_in;
  end
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign err         = err_r;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_r  <= '0;
      ptr    <= '0;
      w_r    <= '0;
      cmd_r  <= 2'b00;
      sr_out <= 2'b00;
      gnt    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      req_r  <= req;
      gnt    <= '0;
      done   <= 1'b0;
      err_r  <= 1'b0;
      sr_out <= 2'b00;
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            w_r   <= win;
            gnt   <= NREQ'(1) << win;
            cmd_r <= cmd[{win, 1'b0} +: 2];
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          state  <= ISSUE;
          // The forbidden S=R=1 code never reaches the flip-flop.
          sr_out <= (cmd_r == 2'b11) ? 2'b00 : cmd_r;
          err_r  <= (cmd_r == 2'b11);
        end
        ISSUE: begin
          state <= SETTLE;
          done  <= 1'b1;
          ptr   <= (w_r == PW'(NREQ - 1)) ? '0 : w_r + PW'(1);
        end
        SETTLE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srff_cmd_arbiter.sv
// Directed bench for srff_cmd_arbiter with a behavioural srff model on the shared sr/q wires.
module tb_srff_cmd_arbiter;

  localparam int NREQ = 4;

`ifdef SRFF_ARB_CHECK_EN
  localparam logic EXP_CHK_ERR = 1'b1;
`else
  localparam logic EXP_CHK_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [7:0]      cmd = '0;
  logic            q_in;
  logic [1:0]      sr_out;
  logic [NREQ-1:0] gnt;
  logic            done;
  logic            busy;
  logic            err;
  logic [1:0]      state_dbg;

  logic q_model  = 1'b0;
  logic force_q0 = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  srff_cmd_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cmd       (cmd),
    .q_in      (q_in),
    .sr_out    (sr_out),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // shared srff model
  always @(posedge clk) begin
    case (sr_out)
      2'b10:   q_model <= 1'b1;
      2'b01:   q_model <= 1'b0;
      2'b11:   q_model <= 1'bx;
      default: q_model <= q_model;
    endcase
  end

  assign q_in = force_q0 ? 1'b0 : q_model;

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_g;

    // reset state
    do_reset();
    check("rst_sr_out", sr_out, 8'h0);
    check("rst_gnt", gnt, 8'h0);
    check("rst_done", done, 8'h0);
    check("rst_busy", busy, 8'h0);
    check("rst_err", err, 8'h0);
    check("rst_state", state_dbg, 8'h0);

    // single set command from requester 0
    cmd = 8'b00_00_00_10;
    req = 4'b0001;
    tick();
    check("t1_gnt_k", gnt, 8'h0);
    check("t1_busy_k", busy, 8'h0);
    tick();
    check("t1_gnt", gnt, 8'h1);
    check("t1_busy", busy, 8'h1);
    req = 4'b0000;
    tick();
    check("t1_gnt_off", gnt, 8'h0);
    check("t1_sr_issue", sr_out, 8'h2);
    check("t1_err_issue", err, 8'h0);
    tick();
    check("t1_sr_settle", sr_out, 8'h0);
    check("t1_done", done, 8'h1);
    check("t1_q", q_in, 8'h1);
    check("t1_err_done", err, 8'h0);
    tick();
    check("t1_done_off", done, 8'h0);
    check("t1_busy_off", busy, 8'h0);

    // all requesters held: round robin 0,1,2,3,0 with alternating set/reset
    do_reset();
    cmd = 8'b01_10_01_10;
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      tick();
      exp_g = 8'd1 << (n % 4);
      check("t2_gnt", gnt, exp_g);
      tick();
      check("t2_sr", sr_out, (n % 2 == 0) ? 8'h2 : 8'h1);
      tick();
      tick();
    end

    // illegal command from requester 2 with q=1 beforehand
    do_reset();
    cmd = 8'b00_11_00_00;
    req = 4'b0100;
    tick();
    tick();
    check("t3_gnt", gnt, 8'h4);
    req = 4'b0000;
    tick();
    check("t3_sr_issue", sr_out, 8'h0);
    check("t3_err_issue", err, 8'h1);
    tick();
    check("t3_done", done, 8'h1);
    check("t3_err_done", err, 8'h0);
    check("t3_q_hold", q_in, 8'h1);
    tick();
    check("t3_busy_off", busy, 8'h0);

    // reset during ISSUE aborts; pointer restarts at requester 0
    cmd = 8'b00_00_10_01;
    req = 4'b0010;
    tick();
    tick();
    check("t4_gnt", gnt, 8'h2);
    tick();
    check("t4_sr_issue", sr_out, 8'h2);
    rst = 1'b1;
    tick();
    check("t4_sr_abort", sr_out, 8'h0);
    check("t4_busy_abort", busy, 8'h0);
    check("t4_done_abort", done, 8'h0);
    rst = 1'b0;
    req = 4'b0011;
    tick();
    tick();
    check("t4_gnt_after_rst", gnt, 8'h1);

    // readback mismatch: set while q_in is held at 0
    do_reset();
    force_q0 = 1'b1;
    cmd = 8'b00_00_00_10;
    req = 4'b0001;
    tick();
    tick();
    check("t5_gnt", gnt, 8'h1);
    req = 4'b0000;
    tick();
    check("t5_sr_issue", sr_out, 8'h2);
    tick();
    check("t5_done", done, 8'h1);
    check("t5_err", err, EXP_CHK_ERR);
    tick();
    check("t5_err_off", err, 8'h0);
    force_q0 = 1'b0;

    // request timing around the IDLE sample point
    do_reset();
    cmd = 8'b00_00_10_00;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    check("t6_gnt_late_drop", gnt, 8'h2);
    tick();
    req = 4'b0010;
    tick();
    check("t6_done", done, 8'h1);
    req = 4'b0000;
    tick();
    check("t6_busy_idle", busy, 8'h0);
    tick();
    check("t6_gnt_early_drop", gnt, 8'h0);
    check("t6_busy_early_drop", busy, 8'h0);
    tick();
    check("t6_gnt_still_off", gnt, 8'h0);
    check("t6_busy_still_off", busy, 8'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srff_cmd_arbiter.md
# srff_cmd_arbiter

Round-robin controller that shares one `srff` instance between `NREQ` requesters. Each requester posts a 2-bit SR command. The block grants one requester at a time, drives the shared flip-flop's `sr` input for exactly one clock, then returns `sr` to hold. It blocks the forbidden S=R=1 code and, when configured, reads `q` back to confirm the flip-flop reached the expected state.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `clk`  in  1  system clock, rising edge; same clock as the shared `srff`.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  request, one bit per requester; held high until granted.
- `cmd`  in  2*NREQ  packed commands; requester i uses `cmd[2i+1:2i]`, encoded as {S,R}.
- `q_in`  in  1  `q` output of the shared `srff`.
- `sr_out`  out  2  drives `srff.sr`.
- `gnt`  out  NREQ  one-hot grant pulse, one cycle wide.
- `done`  out  1  one-cycle pulse when a command retires.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  one-cycle pulse on an illegal command or a readback mismatch.

## Operation
- SR encoding: 00 hold, 01 reset (q→0), 10 set (q→1), 11 illegal.
- States:
  - IDLE → GRANT when `req` is non-zero.
  - GRANT → ISSUE, unconditional.
  - ISSUE → SETTLE, unconditional.
  - SETTLE → IDLE, unconditional.
- IDLE: `sr_out`=00. Selects winner w by searching `req` from index `ptr` upward, wrapping modulo NREQ.
- GRANT:
  - Drives `gnt`=one-hot(w).
  - Latches `cmd[w]` into `cmd_r`.
  - Latches `q_in` into `q_prev`.
- Illegal command (`cmd_r`=11): the block substitutes 00, so the flip-flop holds. `err` pulses in the ISSUE cycle. The command still retires normally with `done`.
- ISSUE: `sr_out`=`cmd_r`, or 00 if `cmd_r` was illegal. `sr_out` is non-zero in this cycle only.
- SETTLE:
  - `sr_out`=00.
  - `done` pulses.
  - `ptr` ← (w+1) mod NREQ.
- `ptr` resets to 0, so requester 0 has first priority after reset.
- Expected q after a command:
  - set → 1
  - reset → 0
  - hold or illegal → `q_prev`
- `req` deasserted before its grant: that requester is skipped, with no error.
- `req` held after `done`: treated as a new request. It is served only after every other pending requester, so one requester holding `req` cannot starve the others.
- `cmd` is sampled only in GRANT. Changes after that are ignored.

## Timing
- Reset values: state IDLE, `sr_out`=00, `gnt`=0, `done`=0, `busy`=0, `err`=0, `ptr`=0, `cmd_r`=00, `q_prev`=0.
- All outputs are registered.
- `rst` during any state aborts the operation at the next edge and restores reset values.
  - `sr_out` returns to 00 at that edge.
  - A command in flight may or may not have reached the flip-flop; no `done` is issued for it.
- Latency, with `req` first seen high at edge k:
  - `gnt` high after edge k+1.
  - `sr_out` active after edge k+2.
  - The `srff` captures the command at edge k+3.
  - `done` high after edge k+3.
- Throughput: one command per 4 cycles. IDLE always lasts at least one cycle between commands.
- `busy` is high from GRANT through SETTLE.

## Configuration
- `SRFF_ARB_CHECK_EN` defined:
  - In SETTLE, `q_in` is compared with the expected q.
  - A mismatch pulses `err` in the same cycle as `done`.
- Not defined:
  - No readback check; `q_in` is ignored and `q_prev` is not implemented.
  - `err` pulses only for illegal commands.

## Test plan
- After reset, `req`=0001, `cmd[1:0]`=10 → `gnt`=0001 one cycle later, `sr_out`=10 for exactly one cycle, `q_in`=1 at `done`, `err`=0.
- `req`=1111 held, with commands set/reset/set/reset → grants in order 0,1,2,3, then 0 again. Each grant is 4 cycles apart and `sr_out` alternates 10, 01.
- `req`=0100 with `cmd[5:4]`=11, and q=1 beforehand → `sr_out` stays 00, `err` pulses in ISSUE, `done` pulses, q stays 1.
- Assert `rst` during the ISSUE state → next cycle `sr_out`=00, `busy`=0, no `done`. The next grant goes to requester 0.
- With `SRFF_ARB_CHECK_EN` defined, a set command while the bench forces `q_in`=0 → `err` and `done` pulse together. Without the macro, `err` stays 0.
- `req`=0010 dropped to 0000 in the same cycle IDLE samples it → that sample still produces a grant. Dropping `req` one cycle before IDLE samples it → no grant, `busy` stays 0.
